sa_sequencer: RTL

Command-driven run sequencer for the 4x4 systolic array. Decodes RUN and ABORT command bytes from the UART receive path and plays out one complete matrix pass on the array:
- an accumulator clear;
- skewed feed shifts;
- drain shifts;
- a completion pulse.

It sits between the UART front end and the array, taking over the single-pulse shift generation for whole-pass operation. The host no longer issues one shift command per step.

---
 rtl/sa_sequencer_if.sv | 22 ++
 rtl/sa_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sa_sequencer_if.sv
// Command/array bus of the run sequencer: UART byte strobe in, array control pulses out.
// No backpressure; the sequencer (slave) samples uart_* every cycle and drives the rest.
interface sa_sequencer_if;
  logic       uart_rw;
  logic [7:0] uart_in;
  logic       clear_acc;
  logic       shift;
  logic [3:0] feed_idx;
  logic       out_valid;
  logic       busy;
  logic       done;

  modport master (
    output uart_rw, uart_in,
    input  clear_acc, shift, feed_idx, out_valid, busy, done
  );

  modport slave (
    input  uart_rw, uart_in,
    output clear_acc, shift, feed_idx, out_valid, busy, done
  );
endinterface

// File: rtl/sa_sequencer.sv
// Plays one systolic pass (clear, 2N-1 feed shifts, N drain shifts, done) per RUN byte; clear_acc 2 cycles after the byte.
// No backpressure: RUN while busy is ignored, ABORT cancels at once; all outputs registered.
module sa_sequencer #(
  parameter logic [7:0] RUN_ADDR   = 8'h03,
  parameter logic [7:0] ABORT_ADDR = 8'h04,
  parameter int         SA_SIZE    = 4,
  parameter int         SHIFT_GAP  = 4
) (
  input logic           Clock,
  input logic           rst,
  sa_sequencer_if.slave bus
);

  if (SA_SIZE < 2 || SA_SIZE > 5) begin : g_bad_size
    $error("sa_sequencer: SA_SIZE must be 2..5 so feed_idx fits in 4 bits");
  end
  if (SHIFT_GAP < 1 || SHIFT_GAP > 15) begin : g_bad_gap
    $error("sa_sequencer: SHIFT_GAP must be 1..15");
  end

  localparam logic [3:0] FEED_LAST  = 4'(2 * SA_SIZE - 2);
  localparam logic [3:0] LAST_IDX   = 4'(3 * SA_SIZE - 2);
  localparam logic [3:0] GAP_RELOAD = 4'(SHIFT_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] step_q, step_d, step_nxt;
  logic [3:0] cnt_q, cnt_d;
  logic       run_q, run_qq, abort_q, abort_qq;
  logic       run_start, abort_start;
  logic       clear_q, clear_d, shift_q, shift_d, ov_q, ov_d, busy_q, done_q, done_d;
  logic [3:0] idx_q, idx_d;

  // Hits are registered first, so a held byte produces a single start pulse.
  assign run_start   = run_q & ~run_qq;
  assign abort_start = abort_q & ~abort_qq;
  assign step_nxt    = step_q + 4'd1;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    clear_d = 1'b0;
    shift_d = 1'b0;
    idx_d   = 4'd0;
    ov_d    = 1'b0;
    done_d  = 1'b0;
    if (abort_start) begin
      state_d = S_IDLE;
      step_d  = 4'd0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_start) begin
            state_d = S_CLEAR;
            clear_d = 1'b1;
          end
        end
        S_CLEAR: begin
          state_d = S_FEED;
          shift_d = 1'b1;
          step_d  = 4'd0;
          cnt_d   = GAP_RELOAD;
        end
        S_FEED, S_DRAIN: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (step_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            step_d  = step_nxt;
            shift_d = 1'b1;
            idx_d   = step_nxt;
            cnt_d   = GAP_RELOAD;
            ov_d    = (step_nxt > FEED_LAST);
            state_d = (step_nxt > FEED_LAST) ? S_DRAIN : S_FEED;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (rst) begin
      state_q  <= S_IDLE;
      step_q   <= 4'd0;
      cnt_q    <= 4'd0;
      run_q    <= 1'b0;
      run_qq   <= 1'b0;
      abort_q  <= 1'b0;
      abort_qq <= 1'b0;
      clear_q  <= 1'b0;
      shift_q  <= 1'b0;
      idx_q    <= 4'd0;
      ov_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      run_q    <= bus.uart_rw && (bus.uart_in == RUN_ADDR);
      run_qq   <= run_q;
      abort_q  <= bus.uart_rw && (bus.uart_in == ABORT_ADDR);
      abort_qq <= abort_q;
      clear_q  <= clear_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      ov_q     <= ov_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
    end
  end

  assign bus.clear_acc = clear_q;
  assign bus.shift     = shift_q;
  assign bus.feed_idx  = idx_q;
  assign bus.out_valid = ov_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
